// File: rtl/result_writer.sv
// Result writer: gathers four signed ALU results per column and writes them, sign-extended,
// into a 4x4 SRAM region. It pulses web after each column and all_done after the last one.
module result_writer #(
    parameter int RES_W  = 19,
    parameter int MEM_W  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic              ALU_en,
    input  logic              res_valid,
    input  logic [RES_W-1:0]  res_data,
    output logic              web,
    output logic              ram_csn,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [MEM_W-1:0]  ram_d,
    output logic              all_done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic logic [MEM_W-1:0] sign_extend(input logic [RES_W-1:0] value);
        return MEM_W'($signed(value));
    endfunction

    state_t             state_r, state_s;
    logic [1:0]         col_cnt_r, col_cnt_s;
    logic [1:0]         row_cnt_r, row_cnt_s;
    logic [1:0]         wr_idx_r, wr_idx_s;
    logic [1:0]         next_idx_s;
    logic               web_r, web_s;
    logic               all_done_r, all_done_s;
    logic               err_r, err_s;
    logic               ram_csn_r, ram_csn_s;
    logic               ram_wen_r, ram_wen_s;
    logic [ADDR_W-1:0]  ram_addr_r, ram_addr_s;
    logic [MEM_W-1:0]   ram_d_r, ram_d_s;
    logic               capture_s;
    logic [RES_W-1:0]   buf_r [4];

    assign next_idx_s = wr_idx_r + 2'd1;

    // Next-state and next-output logic; SRAM strobes are idle unless a write is scheduled.
    always_comb begin
        state_s    = state_r;
        col_cnt_s  = col_cnt_r;
        row_cnt_s  = row_cnt_r;
        wr_idx_s   = wr_idx_r;
        web_s      = 1'b0;
        all_done_s = 1'b0;
        ram_csn_s  = 1'b1;
        ram_wen_s  = 1'b1;
        ram_addr_s = ram_addr_r;
        ram_d_s    = ram_d_r;
        capture_s  = 1'b0;
        // Any result that cannot be captured is dropped and flagged.
        err_s      = err_r | (res_valid & ~((state_r == COLLECT) & ALU_en));
        case (state_r)
            IDLE: begin
                if (start_in) begin
                    state_s   = COLLECT;
                    col_cnt_s = 2'd0;
                    row_cnt_s = 2'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (res_valid && ALU_en) begin
                    capture_s = 1'b1;
                    if (row_cnt_r == 2'd3) begin
                        // Row 0 goes out on the cycle right after the last capture.
                        row_cnt_s  = 2'd0;
                        wr_idx_s   = 2'd0;
                        state_s    = WRITE;
                        ram_csn_s  = 1'b0;
                        ram_wen_s  = 1'b0;
                        ram_addr_s = ADDR_W'({col_cnt_r, 2'd0});
                        ram_d_s    = sign_extend(buf_r[0]);
                    end else begin
                        row_cnt_s = row_cnt_r + 2'd1;
                    end
                end else begin
                    state_s = COLLECT;
                end
            end
            WRITE: begin
                if (wr_idx_r == 2'd3) begin
                    state_s    = DONE;
                    web_s      = 1'b1;
                    all_done_s = (col_cnt_r == 2'd3);
                end else begin
                    wr_idx_s   = next_idx_s;
                    ram_csn_s  = 1'b0;
                    ram_wen_s  = 1'b0;
                    ram_addr_s = ADDR_W'({col_cnt_r, next_idx_s});
                    ram_d_s    = sign_extend(buf_r[next_idx_s]);
                end
            end
            DONE: begin
                if (col_cnt_r == 2'd3) begin
                    state_s = IDLE;
                end else begin
                    col_cnt_s = col_cnt_r + 2'd1;
                    state_s   = COLLECT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            col_cnt_r  <= 2'd0;
            row_cnt_r  <= 2'd0;
            wr_idx_r   <= 2'd0;
            web_r      <= 1'b0;
            all_done_r <= 1'b0;
            err_r      <= 1'b0;
            ram_csn_r  <= 1'b1;
            ram_wen_r  <= 1'b1;
            ram_addr_r <= {ADDR_W{1'b0}};
            ram_d_r    <= {MEM_W{1'b0}};
        end else begin
            state_r    <= state_s;
            col_cnt_r  <= col_cnt_s;
            row_cnt_r  <= row_cnt_s;
            wr_idx_r   <= wr_idx_s;
            web_r      <= web_s;
            all_done_r <= all_done_s;
            err_r      <= err_s;
            ram_csn_r  <= ram_csn_s;
            ram_wen_r  <= ram_wen_s;
            ram_addr_r <= ram_addr_s;
            ram_d_r    <= ram_d_s;
        end
    end

    // Column buffer; contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            buf_r[row_cnt_r] <= res_data;
        end
    end

    assign web      = web_r;
    assign all_done = all_done_r;
    assign err      = err_r;
    assign ram_csn  = ram_csn_r;
    assign ram_wen  = ram_wen_r;
    assign ram_addr = ram_addr_r;
    assign ram_d    = ram_d_r;

endmodule

// File: tb/tb_result_writer.sv
// Scoreboard bench for result_writer: the stimulus pushes expected SRAM writes and web pulses
// (with the cycle in which each one must appear), and a negedge monitor pops and checks them.
module tb_result_writer;

    logic        clk;
    logic        rst;
    logic        start_in;
    logic        ALU_en;
    logic        res_valid;
    logic [18:0] res_data;
    logic        web;
    logic        ram_csn;
    logic        ram_wen;
    logic [3:0]  ram_addr;
    logic [31:0] ram_d;
    logic        all_done;
    logic        err;

    result_writer #(.RES_W(19), .MEM_W(32), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .ALU_en(ALU_en),
        .res_valid(res_valid), .res_data(res_data), .web(web),
        .ram_csn(ram_csn), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_d(ram_d), .all_done(all_done), .err(err)
    );

    typedef struct { int cyc; logic [3:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; bit done; } wb_t;

    wr_t wq[$];
    wb_t bq[$];
    int  tests;
    int  failed;
    int  cyc;
    bit  exp_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write or web pulse must match the head of its expectation queue.
    always @(negedge clk) begin
        if (rst) begin
            if (!ram_wen || !ram_csn) begin
                if (wq.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write", ram_addr, ram_d);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                    chk("wr_addr", 64'(ram_addr), 64'(e.addr));
                    chk("wr_data", 64'(ram_d), 64'(e.data));
                    chk("wr_strobes", {62'd0, ram_csn, ram_wen}, 64'd0);
                end
            end
            if (web) begin
                if (bq.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_web: got web 1 expected 0");
                end else begin
                    wb_t b;
                    b = bq.pop_front();
                    chk("web_cycle", 64'(cyc), 64'(b.cyc));
                    chk("all_done", 64'(all_done), 64'(b.done));
                end
            end else if (all_done) begin
                tests++;
                failed++;
                $display("FAIL all_done_without_web: got all_done 1 expected 0");
            end
        end
    end

    function automatic int rand_res();
        return int'($urandom_range(0, 524287)) - 262144;
    endfunction

    task automatic run_column(input int col, input bit gated, input bit late,
                              input bit stray, input bit abort, input bit fixed);
        int vals[4];
        int n;
        vals[0] = fixed ? 1  : rand_res();
        vals[1] = fixed ? 2  : rand_res();
        vals[2] = fixed ? -1 : rand_res();
        vals[3] = fixed ? -2 : rand_res();
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(0, 2)) begin
                ALU_en = 1'($urandom_range(0, 1));
                tick();
            end
            ALU_en = 1'b1;
            if (gated && r == 1) begin
                res_data  = 19'(rand_res());
                res_valid = 1'b1;
                ALU_en    = 1'b0;
                tick();
                res_valid = 1'b0;
                ALU_en    = 1'b1;
                exp_err   = 1'b1;
                chk("gated_err", 64'(err), 64'd1);
            end
            if (late && r == 2) begin
                start_in = 1'b1;
                tick();
                start_in = 1'b0;
            end
            res_data  = 19'(vals[r]);
            res_valid = 1'b1;
            tick();
            res_valid = 1'b0;
        end
        n = cyc;
        for (int r = 0; r < 4; r++) begin
            wr_t e;
            e.cyc  = n + r;
            e.addr = 4'(col * 4 + r);
            e.data = 32'(vals[r]);
            wq.push_back(e);
        end
        begin
            wb_t b;
            b.cyc  = n + 4;
            b.done = (col == 3);
            bq.push_back(b);
        end
        ALU_en = 1'b0;
        if (abort) begin
            tick();
            #1 rst = 1'b0;
            #1;
            chk("abort_wen", 64'(ram_wen), 64'd1);
            chk("abort_csn", 64'(ram_csn), 64'd1);
            chk("abort_addr", 64'(ram_addr), 64'd0);
            chk("abort_d", 64'(ram_d), 64'd0);
            chk("abort_err", 64'(err), 64'd0);
            exp_err = 1'b0;
            wq.delete();
            bq.delete();
            return;
        end
        if (stray) begin
            res_data  = 19'(rand_res());
            res_valid = 1'b1;
            ALU_en    = 1'b1;
            tick();
            res_valid = 1'b0;
            ALU_en    = 1'b0;
            exp_err   = 1'b1;
            chk("stray_err", 64'(err), 64'd1);
            repeat (4) tick();
        end else begin
            repeat (5) tick();
        end
    endtask

    task automatic run_job(input bit fixed, input int gated_col, input int late_col, input int stray_col);
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            run_column(c, c == gated_col, c == late_col, c == stray_col, 1'b0, fixed);
        end
        chk("err_sticky", 64'(err), 64'(exp_err));
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("web_drained", 64'(bq.size()), 64'd0);
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        cyc       = 0;
        exp_err   = 1'b0;
        rst       = 1'b0;
        start_in  = 1'b0;
        ALU_en    = 1'b0;
        res_valid = 1'b0;
        res_data  = 19'd0;
        tick();
        chk("rst_csn", 64'(ram_csn), 64'd1);
        chk("rst_wen", 64'(ram_wen), 64'd1);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        chk("rst_d", 64'(ram_d), 64'd0);
        chk("rst_web", 64'(web), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Reference job: 1, 2, -1, -2 in every column, no protocol errors.
        run_job(1'b1, -1, -1, -1);

        // Random job with a gated result, a late start and a stray result during WRITE.
        run_job(1'b0, 0, 1, 2);

        // Reset during the second write of column 1, then a clean job from address 0.
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        run_column(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_column(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_job(1'b0, -1, -1, -1);

        // A result presented while idle is dropped and flagged.
        res_data  = 19'(rand_res());
        res_valid = 1'b1;
        ALU_en    = 1'b1;
        tick();
        res_valid = 1'b0;
        ALU_en    = 1'b0;
        chk("idle_stray_err", 64'(err), 64'd1);
        repeat (6) tick();
        chk("final_wq_drained", 64'(wq.size()), 64'd0);
        chk("final_err_sticky", 64'(err), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter RES_W, default 19: width of one signed ALU result.
REQ-002 Parameter MEM_W, default 32: SRAM word width; RES_W <= MEM_W.
REQ-003 Parameter ADDR_W, default 4: SRAM address width, covering 4 columns x 4 rows.
REQ-004 clk  input  1  clock; all state updates occur on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start_in  input  1  job start; the same pulse is delivered to the sequencing controller.
REQ-007 ALU_en  input  1  high while the controller is in its compute state.
REQ-008 res_valid  input  1  one ALU result present on res_data this cycle.
REQ-009 res_data  input  RES_W  signed ALU result; results arrive in row order 0..3 within a column.
REQ-010 web  output  1  column-stored pulse, high for exactly 1 cycle; the controller advances to its next column on this pulse.
REQ-011 ram_csn  output  1  SRAM chip select, active-low.
REQ-012 ram_wen  output  1  SRAM write enable, active-low.
REQ-013 ram_addr  output  ADDR_W  SRAM write address.
REQ-014 ram_d  output  MEM_W  SRAM write data.
REQ-015 all_done  output  1  job-complete pulse, 1 cycle.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 The block SHALL implement the FSM states IDLE, COLLECT, WRITE and DONE.
REQ-018 In IDLE, start_in=1 SHALL cause a transition to COLLECT on the next edge, clearing col_cnt and row_cnt to 0 and leaving err unchanged.
REQ-019 In states other than IDLE, start_in SHALL be ignored.
REQ-020 In COLLECT, each cycle with res_valid=1 and ALU_en=1 SHALL store res_data in buffer entry row_cnt and increment row_cnt.
REQ-021 The 4th capture in COLLECT (row_cnt=3) SHALL transition to WRITE and wrap row_cnt to 0.
REQ-022 The block SHALL assert err (err=1) on res_valid=1 in any state other than COLLECT, or on res_valid=1 with ALU_en=0; such data SHALL be dropped.
REQ-023 WRITE SHALL last exactly 4 cycles, writing row r (r = 0..3) in cycle r with ram_csn=0, ram_wen=0, ram_addr={col_cnt,r[1:0]}, and ram_d = buffer[r] sign-extended to MEM_W.
REQ-024 Outside WRITE, the block SHALL hold ram_csn=1 and ram_wen=1, and hold ram_addr and ram_d at their last values.
REQ-025 After the 4th write, the block SHALL enter DONE for 1 cycle with web=1.
REQ-026 From DONE, if col_cnt=3, the block SHALL set all_done=1 in that same DONE cycle and go to IDLE; otherwise it SHALL increment col_cnt and go to COLLECT.
REQ-027 Latency from the 4th capture edge to the first write cycle SHALL be 1 cycle; from the 4th capture to web=1 SHALL be 5 cycles.
REQ-028 Results arriving during WRITE or DONE SHALL raise err; they are not buffered.
REQ-029 web and all_done SHALL be registered outputs, glitch-free and never high for more than 1 consecutive cycle.
REQ-030 A complete job SHALL write exactly 16 words to addresses 0..15 in ascending order.

Reset
REQ-031 On rst=0, the block SHALL immediately enter IDLE with col_cnt=0, row_cnt=0, web=0, all_done=0, err=0, ram_csn=1, ram_wen=1, ram_addr=0 and ram_d=0; buffer contents are don't-care.
REQ-032 Reset mid-WRITE SHALL abort the current write: ram_wen deasserts asynchronously and no further writes occur until a new start_in.
REQ-033 err SHALL clear only on reset.

Verification
REQ-034 The bench SHALL cover a full job: start_in, then 4 columns of res_data=1,2,-1,-2 -> 16 writes at addresses 0..15 with data 0x00000001, 0x00000002, 0xFFFFFFFF, 0xFFFFFFFE; 4 web pulses; all_done in the 4th DONE cycle.
REQ-035 The bench SHALL cover timing: capture the 4th result at edge N -> ram_wen=0 in cycles N+1..N+4 and web=1 in cycle N+5.
REQ-036 The bench SHALL cover a stray result: res_valid=1 during WRITE -> err=1 persisting, with the in-flight column still written correctly.
REQ-037 The bench SHALL cover reset mid-operation: rst=0 during the 2nd write of column 1 -> ram_wen=1 immediately, state IDLE, a new start_in writes again from address 0.
REQ-038 The bench SHALL cover a gated result: res_valid=1 with ALU_en=0 in COLLECT -> the result is not captured, err=1, and row_cnt is unchanged.
REQ-039 The bench SHALL cover a late start: start_in=1 in COLLECT -> ignored, col_cnt and row_cnt unchanged.
